// File: rtl/add32_seq.sv
// Two-pass 32-bit adder sequencer around an external combinational HALF_W-bit adder.
// The low half is added first and its carry is chained into the high-half pass.
module add32_seq #(
    parameter int HALF_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   in_a,
    input  logic [2*HALF_W-1:0]   in_b,
    input  logic                  in_cin,
    output logic [HALF_W-1:0]     add_in0,
    output logic [HALF_W-1:0]     add_in1,
    output logic                  add_cin,
    input  logic [HALF_W-1:0]     add_out,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*HALF_W-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam int W = 2 * HALF_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [W-1:0]        a_r;
    logic [W-1:0]        b_r;
    logic                cin_r;
    logic [HALF_W-1:0]   sum_lo_r;
    logic                carry_r;
    logic                accept_s;

    // Overflow only when both operands share a sign and the result sign differs;
    // the carry-in takes no part in the sign test.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign accept_s = in_valid & in_ready;

    // Next-state, handshake readiness and adder operand steering.
    always_comb begin
        state_nx_s = state_r;
        in_ready   = 1'b0;
        add_in0    = '0;
        add_in1    = '0;
        add_cin    = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx_s = LO;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            LO: begin
                add_in0    = a_r[HALF_W-1:0];
                add_in1    = b_r[HALF_W-1:0];
                add_cin    = cin_r;
                state_nx_s = HI;
            end
            HI: begin
                add_in0    = a_r[W-1:HALF_W];
                add_in1    = b_r[W-1:HALF_W];
                add_cin    = carry_r;
                state_nx_s = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        state_nx_s = LO;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, operand latches, low-half capture and the registered result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            cin_r     <= 1'b0;
            sum_lo_r  <= '0;
            carry_r   <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                a_r   <= in_a;
                b_r   <= in_b;
                cin_r <= in_cin;
            end
            if (state_r == LO) begin
                sum_lo_r <= add_out;
                carry_r  <= add_cout;
            end
            // Result registers change only on the high pass, so they hold through DONE.
            if (state_r == HI) begin
                out_sum   <= {add_out, sum_lo_r};
                out_cout  <= add_cout;
                out_ovf   <= signed_ovf(a_r[W-1], b_r[W-1], add_out[HALF_W-1]);
                out_valid <= 1'b1;
            end else if ((state_r == DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_add32_seq.sv
// Self-checking bench for add32_seq: behavioural adder, transaction-level reference
// model with a per-cycle compare, directed literal cases and randomized traffic.
module tb_add32_seq;

    localparam int HALF_W = 16;
    localparam int W      = 2 * HALF_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_a;
    logic [W-1:0]      in_b;
    logic              in_cin;
    logic [HALF_W-1:0] add_in0;
    logic [HALF_W-1:0] add_in1;
    logic              add_cin;
    logic [HALF_W-1:0] add_out;
    logic              add_cout;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_sum;
    logic              out_cout;
    logic              out_ovf;

    int checks = 0;
    int errors = 0;
    int n_ret  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // The external half-width adder, behaviourally.
    assign {add_cout, add_out} = {1'b0, add_in0} + {1'b0, add_in1} + {{HALF_W{1'b0}}, add_cin};

    add32_seq #(.HALF_W(HALF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .add_in0(add_in0), .add_in1(add_in1), .add_cin(add_cin),
        .add_out(add_out), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction accepted at edge N is in flight for two edges,
    // then its 33-bit sum is presented until retired.
    int           m_cnt = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic         m_cin = 1'b0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0, m_ovf = 1'b0;
    logic [W:0]   m_pend;
    logic         m_lo_carry;
    wire          m_ready = (m_cnt == 0) && (!m_valid || out_ready);

    assign m_pend     = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
    assign m_lo_carry = ((m_a % 33'h10000) + (m_b % 33'h10000) + m_cin) >= 33'h10000;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            m_valid <= 1'b0;
            m_sum   <= '0;
            m_cout  <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_sum   <= m_pend[W-1:0];
                m_cout  <= m_pend[W];
                m_ovf   <= (m_a[W-1] == m_b[W-1]) && (m_pend[W-1] != m_a[W-1]);
            end else if (m_valid && out_ready) begin
                m_valid <= 1'b0;
            end
            if (in_valid && m_ready) begin
                m_a   <= in_a;
                m_b   <= in_b;
                m_cin <= in_cin;
                m_cnt <= 2;
            end
        end
    end

    // Compare DUT against the model mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", in_ready, m_ready);
            chk("out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("out_sum", out_sum, m_sum);
                chk("out_cout", out_cout, m_cout);
                chk("out_ovf", out_ovf, m_ovf);
                if (out_ready) n_ret++;
            end
            if (m_cnt == 2) begin
                chk("lo_in0", add_in0, m_a[HALF_W-1:0]);
                chk("lo_in1", add_in1, m_b[HALF_W-1:0]);
                chk("lo_cin", add_cin, m_cin);
            end else if (m_cnt == 1) begin
                chk("hi_in0", add_in0, m_a[W-1:HALF_W]);
                chk("hi_in1", add_in1, m_b[W-1:HALF_W]);
                chk("hi_cin", add_cin, m_lo_carry);
            end else begin
                chk("idle_in0", add_in0, 16'h0000);
                chk("idle_in1", add_in1, 16'h0000);
                chk("idle_cin", add_cin, 1'b0);
            end
        end
    end

    // Present operands and hold them until accepted; returns #1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit hs;
        int n;
        hs = 1'b0;
        n  = 0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    // Count edges from acceptance until out_valid.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        send(a, b, cin);
        wait_valid(lat);
        chk({name, "_lat"}, lat, 2);
        chk({name, "_sum"}, out_sum, es);
        chk({name, "_cout"}, out_cout, ec);
        chk({name, "_ovf"}, out_ovf, eo);
    endtask

    logic [W-1:0] corners [7] = '{32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                                  32'h0000FFFF, 32'hFFFF0000, 32'h00010000};

    function automatic logic [W-1:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 6)];
        return $urandom;
    endfunction

    initial begin
        int lat;
        int sent;
        int ret0;
        int cyc;
        bit hs;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_sum", out_sum, 32'h0);
        cmp_en = 1'b1;

        // Basic add with LO-pass port check.
        send(32'h00000001, 32'h00000001, 1'b1);
        chk("basic_lo_in0", add_in0, 16'h0001);
        chk("basic_lo_in1", add_in1, 16'h0001);
        chk("basic_lo_cin", add_cin, 1'b1);
        wait_valid(lat);
        chk("basic_lat", lat, 2);
        chk("basic_sum", out_sum, 32'h00000003);
        chk("basic_cout", out_cout, 1'b0);
        chk("basic_ovf", out_ovf, 1'b0);

        // Half-boundary carry into the HI pass.
        send(32'h0000FFFF, 32'h00000001, 1'b0);
        @(posedge clk);
        #1;
        chk("half_hi_cin", add_cin, 1'b1);
        wait_valid(lat);
        chk("half_sum", out_sum, 32'h00010000);
        chk("half_cout", out_cout, 1'b0);
        chk("half_ovf", out_ovf, 1'b0);

        directed("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0);
        directed("negovf", 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        directed("posovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);

        // Backpressure: result must hold and new operands must wait.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        directed("bp", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);
        in_a = 32'h00000010; in_b = 32'h00000020; in_cin = 1'b1; in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_sum", out_sum, 32'h23456789);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_retired", out_valid, 1'b0);
        wait_valid(lat);
        chk("bp_next_lat", lat, 2);
        chk("bp_next_sum", out_sum, 32'h00000031);

        // Reset while in HI abandons the transaction.
        @(posedge clk);
        #1;
        send(32'hAAAA5555, 32'h5555AAAA, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_sum", out_sum, 32'h0);
        chk("midrst_out_cout", out_cout, 1'b0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("midrst_no_result", out_valid, 1'b0);
        end

        // Randomized traffic with random backpressure.
        sent = 0;
        ret0 = n_ret;
        cyc  = 0;
        while (sent < 300 && cyc < 20000) begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && sent < 300 && $urandom_range(0, 2) != 0) begin
                in_a = pick(); in_b = pick(); in_cin = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("rand_sent", sent, 300);
        chk("rand_results", n_ret - ret0, sent);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
